// File: rtl/lapido_fetch_stage_pkg.sv
// Shared definitions for the LAPI DOpaCA LAMBA fetch stage: HALT opcode,
// bubble encoding and the fetch FSM state type.
package lapido_fetch_stage_pkg;

    localparam logic [5:0]  OP_HALT   = 6'b111111;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fs_state_e;

endpackage

// File: rtl/lapido_if_id_reg.sv
// IF/ID pipeline register. Bubble beats load; with neither asserted the
// register holds its contents.
module lapido_if_id_reg
    import lapido_fetch_stage_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   bubble_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [PC_WIDTH-1:0]    pc_plus1_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]    pc_plus1_o,
    output logic                   valid_o
);

    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    pc_plus1_q;
    logic                   valid_q;

    // A bubble leaves pc_plus1 stale; consumers must qualify it with valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= INSTR_WIDTH'(NOP_INSTR);
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else if (bubble_i) begin
            instr_q    <= INSTR_WIDTH'(NOP_INSTR);
            valid_q    <= 1'b0;
        end else if (load_i) begin
            instr_q    <= instr_i;
            pc_plus1_q <= pc_plus1_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus1_o = pc_plus1_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/lapido_fetch_stage.sv
// Fetch stage: PC, BOOT/RUN/HALT FSM and the IF/ID register.
// Define LAPIDO_FETCH_STATS_EN to add saturating fetch/bubble counters.
module lapido_fetch_stage
    import lapido_fetch_stage_pkg::*;
#(
    parameter int                    PC_WIDTH    = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_addr,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] id_instr,
    output logic [PC_WIDTH-1:0]    id_pc_plus1,
    output logic                   id_valid,
    output logic [5:0]             id_opcode,
    output logic [5:0]             id_funct,
    output logic                   halted,
    output fs_state_e              dbg_state
`ifdef LAPIDO_FETCH_STATS_EN
    ,
    output logic [31:0]            stat_fetched,
    output logic [31:0]            stat_bubbles
`endif
);

    fs_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   pc_plus1;
    logic                  ifid_load;
    logic                  ifid_bubble;
    logic                  halt_seen;

    assign pc_plus1  = pc_q + PC_WIDTH'(1);
    assign halt_seen = id_valid && (id_opcode == OP_HALT);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        case (state_q)
            FS_BOOT: begin
                ifid_bubble = 1'b1;
                state_d     = FS_RUN;
            end
            FS_RUN: begin
                if (redirect) begin
                    pc_d        = redirect_addr;
                    ifid_bubble = 1'b1;
                end else if (flush) begin
                    ifid_bubble = 1'b1;
                    if (!stall) pc_d = pc_plus1;
                end else if (halt_seen) begin
                    // Overrides stall so the HALT word lives in IF/ID for one cycle only.
                    ifid_bubble = 1'b1;
                    state_d     = FS_HALT;
                end else if (!stall) begin
                    pc_d      = pc_plus1;
                    ifid_load = 1'b1;
                end
            end
            FS_HALT: begin
                ifid_bubble = 1'b1;
            end
            default: begin
                state_d = FS_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    lapido_if_id_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ifid_load),
        .bubble_i   (ifid_bubble),
        .instr_i    (imem_data),
        .pc_plus1_i (pc_plus1),
        .instr_o    (id_instr),
        .pc_plus1_o (id_pc_plus1),
        .valid_o    (id_valid)
    );

    assign imem_addr = pc_q;
    assign id_opcode = id_instr[INSTR_WIDTH-1 -: 6];
    assign id_funct  = id_instr[5:0];
    assign halted    = (state_q == FS_HALT);
    assign dbg_state = state_q;

`ifdef LAPIDO_FETCH_STATS_EN
    logic [31:0] fetched_q, bubbles_q;
    logic        bubble_cycle;

    // Every RUN cycle that does not load is a squash, a halt entry or a stall hold.
    assign bubble_cycle = (state_q == FS_RUN) && !ifid_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (ifid_load && (fetched_q != '1))    fetched_q <= fetched_q + 32'd1;
            if (bubble_cycle && (bubbles_q != '1)) bubbles_q <= bubbles_q + 32'd1;
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_lapido_fetch_stage.sv
// Bench for lapido_fetch_stage: directed scenarios then random traffic,
// checked every cycle against a behavioural model through an expected queue.
module tb_lapido_fetch_stage;
  import lapido_fetch_stage_pkg::*;

`ifdef LAPIDO_FETCH_STATS_EN
  localparam int W = 110 + 64;
`else
  localparam int W = 110;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus1;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic        halted;
  fs_state_e   dbg_state;
`ifdef LAPIDO_FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_bubbles;
`endif

  // clock / reset
  always #5 clk = ~clk;

  lapido_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .id_instr      (id_instr),
    .id_pc_plus1   (id_pc_plus1),
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_funct      (id_funct),
    .halted        (halted),
    .dbg_state     (dbg_state)
`ifdef LAPIDO_FETCH_STATS_EN
    ,
    .stat_fetched  (stat_fetched),
    .stat_bubbles  (stat_bubbles)
`endif
  );

  // instruction memory: mem[a] = 0x1000_0000 + a, optionally one HALT word
  logic [31:0] halt_addr = '0;
  bit          halt_en   = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_en && a == halt_addr) return {6'b111111, 26'h0};
    return 32'h1000_0000 + a;
  endfunction

  always_comb imem_data = (halt_en && imem_addr == halt_addr) ? {6'b111111, 26'h0}
                                                               : 32'h1000_0000 + imem_addr;

  // reference model
  logic [31:0] m_pc, m_instr, m_pp1, m_fetched, m_bubbles;
  bit          m_valid, m_halted, m_boot;

  task automatic model_edge(input bit r, input bit s, input bit f, input bit rd,
                            input logic [31:0] ra);
    bit halt_pending;
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pp1 = 32'h0; m_valid = 0;
      m_halted = 0; m_boot = 1; m_fetched = 0; m_bubbles = 0;
    end else if (m_halted) begin
      m_valid = 0; m_instr = 32'h0;
    end else if (m_boot) begin
      m_boot = 0;
    end else begin
      halt_pending = m_valid && (m_instr[31:26] == 6'b111111);
      if (rd) begin
        m_pc = ra; m_valid = 0; m_instr = 32'h0;
        m_bubbles++;
      end else if (f) begin
        m_valid = 0; m_instr = 32'h0;
        if (!s) m_pc = m_pc + 32'd1;
        m_bubbles++;
      end else if (halt_pending) begin
        m_halted = 1; m_valid = 0; m_instr = 32'h0;
        m_bubbles++;
      end else if (s) begin
        m_bubbles++;
      end else begin
        m_instr = mem_word(m_pc);
        m_pp1   = m_pc + 32'd1;
        m_valid = 1;
        m_pc    = m_pc + 32'd1;
        m_fetched++;
      end
    end
  endtask

  function automatic logic [W-1:0] pack_exp();
    logic [W-1:0] v;
    v = {m_halted, m_valid, m_instr, (m_valid ? m_pp1 : 32'h0), m_pc,
         m_instr[31:26], m_instr[5:0]
`ifdef LAPIDO_FETCH_STATS_EN
         , m_fetched, m_bubbles
`endif
        };
    return v;
  endfunction

  function automatic logic [W-1:0] pack_act();
    logic [W-1:0] v;
    v = {halted, id_valid, id_instr, (id_valid ? id_pc_plus1 : 32'h0), imem_addr,
         id_opcode, id_funct
`ifdef LAPIDO_FETCH_STATS_EN
         , stat_fetched, stat_bubbles
`endif
        };
    return v;
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cycle_no = 0;

  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = pack_act();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_%0d: got %h expected %h", cycle_no, a, e);
      end
      cycle_no++;
    end
  end

  // driver
  task automatic step(input bit r, input bit s, input bit f, input bit rd,
                      input logic [31:0] ra);
    @(negedge clk);
    #1;
    rst = r; stall = s; flush = f; redirect = rd; redirect_addr = ra;
    model_edge(r, s, f, rd, ra);
    exp_q.push_back(pack_exp());
  endtask

  task automatic do_reset(input bit h_en, input logic [31:0] h_addr);
    halt_en = h_en;
    halt_addr = h_addr;
    step(1, 0, 0, 0, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit r, s, f, rd;
    logic [31:0] ra;

    // basic fetch, then stall with pc=5's word in IF/ID
    do_reset(0, 0);
    do_reset(0, 0);
    run(7);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    run(2);

    // redirect wins over stall
    step(0, 1, 0, 1, 32'h40);
    run(3);

    // HALT at mem[3], then reset out of HALT
    do_reset(1, 3);
    run(9);
    do_reset(1, 3);
    halt_en = 0;
    run(3);

    // HALT latched then flushed on the next cycle: no halt
    do_reset(1, 3);
    run(5);
    step(0, 0, 1, 0, 0);
    run(4);

    // flush with stall holds pc
    step(0, 1, 1, 0, 0);
    run(2);

    // pc wrap through all-ones
    step(0, 0, 0, 1, 32'hFFFF_FFFE);
    run(5);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 25);
      f  = ($urandom_range(0, 99) < 10);
      rd = ($urandom_range(0, 99) < 8);
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                      : 32'($urandom_range(0, 63));
      if (r) begin
        halt_en   = ($urandom_range(0, 1) == 0);
        halt_addr = 32'($urandom_range(0, 40));
      end
      step(r, s, f, rd, ra);
    end

    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
